// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic feeder: FSM encoding and default widths.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DRAIN_CYCLES = 4;
    localparam int FEED_CYCLES      = 3;

    // A counter must stay at least one bit wide even when no drain is requested.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/systolic_feeder_2x2.sv
// Sequences one 2x2 matrix job into an external systolic array: clear, skewed feed,
// drain, then capture and hand back the result matrix.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DATA_WIDTH-1:0] a_mat,
    input  logic [4*DATA_WIDTH-1:0] b_mat,
    output logic [DATA_WIDTH-1:0]   arr_a0,
    output logic [DATA_WIDTH-1:0]   arr_a1,
    output logic [DATA_WIDTH-1:0]   arr_b0,
    output logic [DATA_WIDTH-1:0]   arr_b1,
    output logic                    arr_start,
    output logic                    arr_clr,
    input  logic [ACC_WIDTH-1:0]    arr_c00,
    input  logic [ACC_WIDTH-1:0]    arr_c01,
    input  logic [ACC_WIDTH-1:0]    arr_c10,
    input  logic [ACC_WIDTH-1:0]    arr_c11,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*ACC_WIDTH-1:0]  c_mat,
    output logic                    busy
);

    localparam int               CNT_W      = cnt_width(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [1:0]       LAST_K     = 2'(FEED_CYCLES - 1);

    state_t                         state, next_state;
    logic [3:0][DATA_WIDTH-1:0]     a_reg, b_reg;
    logic [1:0]                     feed_k, next_k;
    logic [CNT_W-1:0]               drain_cnt;
    logic [DATA_WIDTH-1:0]          nxt_a0, nxt_a1, nxt_b0, nxt_b1;
    logic                           nxt_start, nxt_clr;
    logic                           accept, capture;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && (state == ST_IDLE);
    assign capture   = (next_state == ST_DONE) && (state != ST_DONE);
    assign next_k    = (state == ST_FEED) ? feed_k + 2'd1 : 2'd0;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (in_valid) next_state = ST_CLEAR;
            ST_CLEAR: next_state = ST_FEED;
            ST_FEED:  if (feed_k == LAST_K)
                          next_state = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (drain_cnt == CNT_W'(1)) next_state = ST_DONE;
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operand slots for the coming cycle; element index is row*2+col.
    always_comb begin
        nxt_a0    = '0;
        nxt_a1    = '0;
        nxt_b0    = '0;
        nxt_b1    = '0;
        nxt_start = (next_state == ST_FEED) || (next_state == ST_DRAIN);
        nxt_clr   = (next_state == ST_CLEAR);
        if (next_state == ST_FEED) begin
            case (next_k)
                2'd0: begin
                    nxt_a0 = a_reg[0];
                    nxt_b0 = b_reg[0];
                end
                2'd1: begin
                    nxt_a0 = a_reg[1];
                    nxt_a1 = a_reg[2];
                    nxt_b0 = b_reg[2];
                    nxt_b1 = b_reg[1];
                end
                2'd2: begin
                    nxt_a1 = a_reg[3];
                    nxt_b1 = b_reg[3];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            feed_k    <= '0;
            drain_cnt <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            arr_a0    <= '0;
            arr_a1    <= '0;
            arr_b0    <= '0;
            arr_b1    <= '0;
            arr_start <= 1'b0;
            arr_clr   <= 1'b0;
            c_mat     <= '0;
        end else begin
            state  <= next_state;
            feed_k <= next_k;
            if ((state == ST_FEED) && (next_state == ST_DRAIN))
                drain_cnt <= DRAIN_LOAD;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt - CNT_W'(1);
            if (accept) begin
                a_reg <= a_mat;
                b_reg <= b_mat;
            end
            arr_a0    <= nxt_a0;
            arr_a1    <= nxt_a1;
            arr_b0    <= nxt_b0;
            arr_b1    <= nxt_b1;
            arr_start <= nxt_start;
            arr_clr   <= nxt_clr;
            if (capture)
                c_mat <= {arr_c11, arr_c10, arr_c01, arr_c00};
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2 driving a behavioural 2x2 output-stationary array.
module tb_systolic_feeder_2x2;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int DC  = 4;
    localparam int LAT = 1 + 3 + DC + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [4*DW-1:0] a_mat, b_mat;
    logic [DW-1:0]   arr_a0, arr_a1, arr_b0, arr_b1;
    logic            arr_start, arr_clr;
    logic [AW-1:0]   acc00, acc01, acc10, acc11;
    logic            out_valid, out_ready;
    logic [4*AW-1:0] c_mat;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_feeder_2x2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_mat(a_mat), .b_mat(b_mat),
        .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
        .arr_start(arr_start), .arr_clr(arr_clr),
        .arr_c00(acc00), .arr_c01(acc01), .arr_c10(acc10), .arr_c11(acc11),
        .out_valid(out_valid), .out_ready(out_ready), .c_mat(c_mat), .busy(busy)
    );

    // Array: PE(i,j) multiplies its row operand by its column operand;
    // row operands move right and column operands move down one PE per cycle.
    logic [DW-1:0] ra00, rb00, rb01, ra10;
    always_ff @(posedge clk) begin
        if (arr_clr) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            ra00 <= '0; rb00 <= '0; rb01 <= '0; ra10 <= '0;
        end else if (arr_start) begin
            acc00 <= acc00 + AW'(arr_a0) * AW'(arr_b0);
            acc01 <= acc01 + AW'(ra00) * AW'(arr_b1);
            acc10 <= acc10 + AW'(arr_a1) * AW'(rb00);
            acc11 <= acc11 + AW'(ra10) * AW'(rb01);
            ra00 <= arr_a0; rb00 <= arr_b0; rb01 <= arr_b1; ra10 <= arr_a1;
        end
    end

    function automatic logic [4*DW-1:0] pk(input int e00, input int e01, input int e10, input int e11);
        return {DW'(e11), DW'(e10), DW'(e01), DW'(e00)};
    endfunction

    function automatic logic [4*AW-1:0] pkc(input int e00, input int e01, input int e10, input int e11);
        return {AW'(e11), AW'(e10), AW'(e01), AW'(e00)};
    endfunction

    function automatic logic [4*DW-1:0] ops(input int a0, input int a1, input int b0, input int b1);
        return {DW'(a0), DW'(a1), DW'(b0), DW'(b1)};
    endfunction

    // Reference: plain matrix product, truncated to the result width.
    function automatic logic [4*AW-1:0] ref_matmul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        int ae[2][2];
        int be[2][2];
        logic [4*AW-1:0] r;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ae[i][j] = int'(a[(2*i+j)*DW +: DW]);
                be[i][j] = int'(b[(2*i+j)*DW +: DW]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                r[(2*i+j)*AW +: AW] = AW'(ae[i][0] * be[0][j] + ae[i][1] * be[1][j]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lat = edges from the acceptance edge to the first edge where out_valid is high.
    task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input int ready_delay,
                           output logic [4*AW-1:0] c, output int lat);
        int n;
        n = 0;
        out_ready = 1'b0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        a_mat = a;
        b_mat = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a_mat = $urandom;
        b_mat = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        for (int d = 0; d < ready_delay; d++) step();
        c = c_mat;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [4*DW-1:0] a;
        logic [4*DW-1:0] b;
        logic [4*AW-1:0] c;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*DW-1:0] exA, exB, ra, rb;
        logic [4*AW-1:0] exC, got, c1, c2;
        int lat, cnt, cyc, acc1, acc2, hs1, hs2, n_acc, n_hs, clr_cnt;
        int tr[3][4];
        logic switch_pending;

        exA = pk(1, 2, 3, 4);
        exB = pk(5, 6, 7, 8);
        exC = pkc(19, 22, 43, 50);
        tr = '{'{1, 0, 5, 0}, '{2, 3, 7, 6}, '{0, 4, 0, 8}};
        vecs[0] = '{"example",  exA,               exB,               exC};
        vecs[1] = '{"identity", pk(1, 0, 0, 1),    pk(9, 8, 7, 6),    pkc(9, 8, 7, 6)};
        vecs[2] = '{"max",      pk(255, 255, 255, 255), pk(255, 255, 255, 255),
                    pkc(16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02)};
        vecs[3] = '{"zeros",    pk(0, 0, 0, 0),    pk(3, 4, 5, 6),    pkc(0, 0, 0, 0)};
        vecs[4] = '{"swap",     pk(0, 1, 1, 0),    pk(1, 2, 3, 4),    pkc(3, 4, 1, 2)};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_mat = '0; b_mat = '0;
        step(); step();
        check("reset_ctrl", {in_ready, out_valid, busy, arr_start, arr_clr}, 5'b10000);
        check("reset_ops", ops(arr_a0, arr_a1, arr_b0, arr_b1), '0);
        check("reset_cmat", c_mat, '0);
        rst = 1'b1;
        step();
        check("post_reset_ready", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].a, vecs[i].b, 0, got, lat);
            check({"tbl_c_", vecs[i].name}, got, vecs[i].c);
            check({"tbl_lat_", vecs[i].name}, 64'(lat), 64'(LAT));
        end

        // Cycle-by-cycle trace of the example job, then a stalled result.
        a_mat = exA; b_mat = exB; in_valid = 1'b1;
        step();
        in_valid = 1'b0; a_mat = pk(77, 77, 77, 77); b_mat = pk(66, 66, 66, 66);
        check("clear_ctrl", {arr_clr, arr_start, busy, in_ready}, 4'b1010);
        check("clear_ops", ops(arr_a0, arr_a1, arr_b0, arr_b1), '0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("feed%0d_ops", k), ops(arr_a0, arr_a1, arr_b0, arr_b1),
                  ops(tr[k][0], tr[k][1], tr[k][2], tr[k][3]));
            check($sformatf("feed%0d_ctrl", k), {arr_start, arr_clr}, 2'b10);
        end
        for (int d = 0; d < DC; d++) begin
            step();
            check($sformatf("drain%0d", d), {arr_start, arr_clr, out_valid, ops(arr_a0, arr_a1, arr_b0, arr_b1)},
                  {3'b100, 32'd0});
        end
        step();
        check("done_ctrl", {out_valid, arr_start, busy}, 3'b101);
        check("done_cmat", c_mat, exC);
        in_valid = 1'b1; a_mat = pk(9, 9, 9, 9); b_mat = pk(9, 9, 9, 9); out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            check($sformatf("stall%0d_ctrl", s), {out_valid, in_ready, busy}, 3'b101);
            check($sformatf("stall%0d_cmat", s), c_mat, exC);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("handshake_ctrl", {out_valid, in_ready, busy, arr_start}, 4'b0100);
        step();
        check("no_buffered_job", busy, 1'b0);

        // Abort in the middle of DRAIN.
        a_mat = exA; b_mat = exB; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) step();
        check("pre_abort_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_ctrl", {out_valid, busy, arr_start, arr_clr, in_ready}, 5'b00001);
        check("abort_ops", ops(arr_a0, arr_a1, arr_b0, arr_b1), '0);
        check("abort_cmat", c_mat, '0);
        step(); step();
        rst = 1'b1;
        #1;
        check("abort_ready", in_ready, 1'b1);
        cnt = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (out_valid) cnt++;
        end
        check("abort_no_valid", 64'(cnt), 64'd0);
        run_job(pk(1, 0, 0, 1), pk(9, 8, 7, 6), 0, got, lat);
        check("after_abort_c", got, pkc(9, 8, 7, 6));
        check("after_abort_lat", 64'(lat), 64'(LAT));

        // Random jobs against the reference product.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_job(ra, rb, $urandom_range(0, 3), got, lat);
            check($sformatf("rand%0d_c", i), got, ref_matmul(ra, rb));
            check($sformatf("rand%0d_lat", i), 64'(lat), 64'(LAT));
        end

        // Back-to-back with in_valid and out_ready held high.
        ra = pk(2, 3, 4, 5);
        rb = pk(6, 7, 8, 9);
        a_mat = ra; b_mat = rb; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_hs = 0; clr_cnt = 0; cyc = 0;
        acc1 = -1; acc2 = -1; hs1 = -1; hs2 = -1; c1 = '0; c2 = '0;
        switch_pending = 1'b0;
        while (n_hs < 2 && cyc < 60) begin
            if (in_valid && in_ready) begin
                if (n_acc == 0) begin acc1 = cyc; switch_pending = 1'b1; end
                else if (n_acc == 1) acc2 = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (n_hs == 0) begin hs1 = cyc; c1 = c_mat; end
                else begin hs2 = cyc; c2 = c_mat; end
                n_hs++;
            end
            if (arr_clr) clr_cnt++;
            step();
            cyc++;
            if (switch_pending) begin
                a_mat = pk(1, 1, 2, 2);
                b_mat = pk(3, 0, 0, 3);
                switch_pending = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_c1", c1, ref_matmul(ra, rb));
        check("b2b_c2", c2, pkc(3, 3, 6, 6));
        check("b2b_latency", 64'(hs1 - acc1), 64'(LAT));
        check("b2b_next_accept", 64'(acc2 - hs1), 64'd1);
        check("b2b_period", 64'(hs2 - hs1), 64'(6 + DC));
        check("b2b_clr_pulses", 64'(clr_cnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
